dmem_responder: RTL and testbench

- Data-memory responder: the target side of the load/store requests issued by the pipelined CPU's Memory stage.
- Accepts one word request at a time over a valid/ready handshake, inserts a programmable number of wait states, then returns a single-cycle response (read data or write acknowledge).
- Drives a stall signal so the pipeline freezes while an access is outstanding.
- 16-bit word-addressed memory with an out-of-range error flag.

---
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the CPU Memory stage (master) and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int unsigned DATA_W = 16
);
  logic              req_valid;
  logic              req_write;
  logic [15:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              stall_o;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall_o
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory behind a one-outstanding valid/ready handshake,
// with programmable wait states, a one-cycle response pulse and a pipeline stall.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_next;
  logic [3:0]        cnt;
  logic              cap_write;
  logic [15:0]       cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              mem_we;
  logic              acc_write;
  logic [15:0]       acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_in_range;
  logic [ADDR_W-1:0] acc_idx;

  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.stall_o   = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.stall_o   = bus.req_valid;
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        bus.stall_o = 1'b1;
        if (cnt == '0) state_next = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the acceptance edge itself, so the
  // access uses the live request in IDLE and the captured copy otherwise.
  always_comb begin
    if (state == IDLE) begin
      acc_write = bus.req_write;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end else begin
      acc_write = cap_write;
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
    end
  end

  assign acc_in_range = (acc_addr[15:ADDR_W] == '0);
  assign acc_idx      = acc_addr[ADDR_W-1:0];
  assign enter_resp   = (state_next == RESP) && (state != RESP);
  assign mem_we       = enter_resp && acc_write && acc_in_range && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        cap_write <= bus.req_write;
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
        cnt       <= CNT_INIT;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        err_q   <= !acc_in_range;
        rdata_q <= (!acc_write && acc_in_range) ? mem[acc_idx] : '0;
      end
    end
  end

  // Array is deliberately left out of reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= acc_wdata;
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with two wait states, one with none,
// each checked against a simple array model of the memory.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_a, rst_z;
  always #5 clk = ~clk;

  dmem_responder_if #(.DATA_W(16)) bus_a ();
  dmem_responder_if #(.DATA_W(16)) bus_z ();

  dmem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a)
  );
  dmem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst_z), .bus(bus_z)
  );

  typedef struct packed {logic [15:0] rdata; logic err;} exp_t;
  typedef struct packed {logic ready; logic stall; logic rsp_valid; logic err; logic [15:0] rdata;} obs_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  exp_t        q_a[$];
  exp_t        q_z[$];
  logic [15:0] model [2][256];

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic obs_t obs(int which);
    obs_t o;
    if (which == 0) begin
      o.ready = bus_a.req_ready; o.stall = bus_a.stall_o; o.rsp_valid = bus_a.rsp_valid;
      o.err = bus_a.rsp_err; o.rdata = bus_a.rsp_rdata;
    end else begin
      o.ready = bus_z.req_ready; o.stall = bus_z.stall_o; o.rsp_valid = bus_z.rsp_valid;
      o.err = bus_z.rsp_err; o.rdata = bus_z.rsp_rdata;
    end
    return o;
  endfunction

  task automatic drive(int which, logic v, logic w, logic [15:0] a, logic [15:0] d);
    if (which == 0) begin
      bus_a.req_valid = v; bus_a.req_write = w; bus_a.req_addr = a; bus_a.req_wdata = d;
    end else begin
      bus_z.req_valid = v; bus_z.req_write = w; bus_z.req_addr = a; bus_z.req_wdata = d;
    end
  endtask

  task automatic check_reset_outputs(int which);
    obs_t o = obs(which);
    check("reset_ctrl", {29'd0, o.ready, o.stall, o.rsp_valid}, 32'b100);
    check("reset_rdata", {16'd0, o.rdata}, 32'h0);
    check("reset_err", {31'd0, o.err}, 32'h0);
  endtask

  // Issue one request (called just after a falling edge) and follow it to the idle cycle after its response.
  task automatic do_req(int which, logic w, logic [15:0] a, logic [15:0] d, bit garbage);
    int   wc = (which == 0) ? 2 : 0;
    int   guard = 0;
    obs_t o;
    exp_t e;
    drive(which, 1'b1, w, a, d);
    #1 o = obs(which);
    while (!o.ready && guard < 20) begin
      @(negedge clk);
      #1 o = obs(which);
      guard++;
    end
    if (!o.ready) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: req_ready stayed 0, expected 1 (dut %0d)", which);
      drive(which, 1'b0, 1'b0, 16'h0, 16'h0);
      return;
    end
    check("stall_on_request", {31'd0, o.stall}, 32'd1);
    e.err   = (a[15:8] != 8'h00);
    e.rdata = (!w && !e.err) ? model[which][a[7:0]] : 16'h0000;
    if (w && !e.err) model[which][a[7:0]] = d;
    if (which == 0) q_a.push_back(e); else q_z.push_back(e);
    @(negedge clk);
    for (int k = 0; k < wc; k++) begin
      #1 o = obs(which);
      check("wait_state", {29'd0, o.ready, o.stall, o.rsp_valid}, 32'b010);
      if (garbage)
        drive(which, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      @(negedge clk);
    end
    #1 o = obs(which);
    check("resp_cycle", {29'd0, o.ready, o.stall, o.rsp_valid}, 32'b001);
    drive(which, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    #1 o = obs(which);
    check("idle_after_resp", {29'd0, o.ready, o.stall, o.rsp_valid}, 32'b100);
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return {8'($urandom_range(1, 255)), 8'($urandom)};
    return {8'h00, 8'($urandom)};
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus_a.rsp_valid) begin
      if (q_a.size() == 0) check("unexpected_rsp_a", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        check("rdata_a", {16'd0, bus_a.rsp_rdata}, {16'd0, e.rdata});
        check("err_a", {31'd0, bus_a.rsp_err}, {31'd0, e.err});
      end
    end
    if (bus_z.rsp_valid) begin
      if (q_z.size() == 0) check("unexpected_rsp_z", 32'd1, 32'd0);
      else begin
        e = q_z.pop_front();
        check("rdata_z", {16'd0, bus_z.rsp_rdata}, {16'd0, e.rdata});
        check("err_z", {31'd0, bus_z.rsp_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0;
    rst_z = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    #3;
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(negedge clk);
    #1 rst_a = 1'b1; rst_z = 1'b1;
    @(negedge clk);
    #1 check_reset_outputs(0);
    check_reset_outputs(1);

    // Fill both memories so every later load has a known value.
    for (int i = 0; i < 256; i++) begin
      do_req(0, 1'b1, 16'(i), (i == 0) ? 16'h0000 : 16'($urandom), 1'b0);
      do_req(1, 1'b1, 16'(i), (i == 0) ? 16'h0000 : 16'($urandom), 1'b0);
    end

    do_req(0, 1'b1, 16'h0005, 16'hBEEF, 1'b0);
    do_req(0, 1'b0, 16'h0005, 16'h0000, 1'b0);
    do_req(0, 1'b1, 16'h0100, 16'h1234, 1'b0);
    do_req(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    do_req(0, 1'b0, 16'h0100, 16'h0000, 1'b0);

    // Store dropped by a reset that lands during its wait states.
    do_req(0, 1'b1, 16'h0003, 16'h5555, 1'b0);
    drive(0, 1'b1, 1'b1, 16'h0003, 16'hAAAA);
    @(negedge clk);
    #1 drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    #2 rst_a = 1'b0;
    #1 check_reset_outputs(0);
    @(negedge clk);
    #1 rst_a = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    do_req(0, 1'b0, 16'h0003, 16'h0000, 1'b0);

    do_req(0, 1'b0, 16'h0007, 16'h0000, 1'b1);
    for (int i = 0; i < 150; i++)
      do_req(0, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom), 1'($urandom_range(0, 1)));

    do_req(1, 1'b1, 16'h0005, 16'hBEEF, 1'b0);
    do_req(1, 1'b0, 16'h0005, 16'h0000, 1'b0);
    do_req(1, 1'b1, 16'h0100, 16'h1234, 1'b0);
    do_req(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 150; i++)
      do_req(1, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom), 1'b0);

    repeat (3) @(negedge clk);
    #1;
    check("pending_a", q_a.size(), 32'd0);
    check("pending_z", q_z.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
